// File: rtl/arf_stream_source.sv
// arf_stream_source
//
// Pull-side data source for ARF dataflow graphs. A host or DMA front-end
// pushes words into a circular-buffer FIFO. The words are then handed, one
// at a time, to a downstream operator that pulls them through a level
// req / pulsed ack handshake. This block is the responder end of the
// operator's req_l/ack_l pair.
//
// Parameters:
//   data_width  word width
//   depth       FIFO entries (power of two, >= 2)
//   addr_width  log2(depth)
//
// Ports:
//   clk       single clock, all state updates on the rising edge
//   rst       synchronous, active-high reset
//   wr_valid  host offers wr_data this cycle
//   wr_ready  FIFO can accept a word (not full), derived from registered state
//   wr_data   pushed word
//   req       level request from the downstream operator
//   ack       one-cycle pulse, dout carries the served word
//   dout      last served word, held stable between acks
//   level     current occupancy, 0..depth
//   count     total words served since reset, wraps modulo 2^32

module arf_stream_source #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [data_width-1:0] wr_data,
    input  logic                  req,
    output logic                  ack,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   level,
    output logic [31:0]           count
);

    localparam logic [addr_width:0] full_level = (addr_width + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width-1:0] wr_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  serve;

    // Full and empty come straight from the registered occupancy, so a slot
    // freed by a serve only becomes visible to the host in the next cycle,
    // and a word pushed into an empty FIFO is not servable at the same edge.
    // Gating serve with ~ack keeps ack from being high in two consecutive
    // cycles, which absorbs the requester's one-cycle delay in dropping req.
    always_comb begin
        full     = (level == full_level);
        empty    = (level == '0);
        wr_ready = ~full;
        push     = wr_valid & ~full;
        serve    = req & ~ack & ~empty;
    end

    // Storage array. It has no reset because stale contents are never
    // readable: the pointers and level are cleared together.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the served-word handshake. The pointers are
    // exactly addr_width bits wide, so with a power-of-two depth they wrap
    // naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ack    <= 1'b0;
            dout   <= '0;
            count  <= '0;
        end else begin
            ack <= serve;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (serve) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count + 32'd1;
            end
            if (push && !serve) begin
                level <= level + 1'b1;
            end else if (serve && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arf_stream_source.sv
// tb_arf_stream_source
//
// Directed bench for arf_stream_source. Inputs are driven and outputs are
// sampled on the falling edge of clk, so every sample shows the state left
// by the preceding rising edge.

module tb_arf_stream_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        req = 1'b0;
    logic        ack;
    logic [31:0] dout;
    logic [3:0]  level;
    logic [31:0] count;

    int checks   = 0;
    int failures = 0;

    arf_stream_source #(
        .data_width(32),
        .depth(8),
        .addr_width(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .req(req),
        .ack(ack),
        .dout(dout),
        .level(level),
        .count(count)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reset, check the cleared state, then idle with req high and no pushes.
    task automatic test_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || dout !== 32'd0 || level !== 4'd0 || count !== 32'd0 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state: ack=%0b dout=%0d level=%0d count=%0d wr_ready=%0b, required 0 0 0 0 1",
                     ack, dout, level, count, wr_ready);
        end
        rst = 1'b0;
        req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || level !== 4'd0 || wr_ready !== 1'b1 || dout !== 32'd0) begin
                failures++;
                $display("[TB] FAIL idle_cycle%0d: ack=%0b level=%0d wr_ready=%0b dout=%0d, required 0 0 1 0",
                         i, ack, level, wr_ready, dout);
            end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    // Push 1,2,3 with req low, then hold req high and collect three pulses.
    task automatic test_push_three();
        int got;
        logic prev_ack;
        got = 0;
        prev_ack = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            wr_valid = 1'b1;
            wr_data = 32'(v);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checks++;
        if (level !== 4'd3) begin
            failures++;
            $display("[TB] FAIL three_level: level=%0d, required 3", level);
        end
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                checks++;
                if (dout !== 32'(got + 1)) begin
                    failures++;
                    $display("[TB] FAIL three_dout%0d: dout=%0d, required %0d", got, dout, got + 1);
                end
                checks++;
                if (prev_ack === 1'b1) begin
                    failures++;
                    $display("[TB] FAIL three_adjacent_ack: ack high=1 on consecutive cycles, required 0");
                end
                got++;
            end
            prev_ack = ack;
        end
        req = 1'b0;
        checks++;
        if (got != 3 || level !== 4'd0 || count !== 32'd3) begin
            failures++;
            $display("[TB] FAIL three_totals: acks=%0d level=%0d count=%0d, required 3 0 3", got, level, count);
        end
    endtask

    // Fill to depth, push while full with a simultaneous serve, then drain.
    task automatic test_full();
        int got;
        got = 0;
        for (int v = 10; v <= 17; v++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data = 32'(v);
        end
        @(negedge clk);
        checks++;
        if (level !== 4'd8 || wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_state: level=%0d wr_ready=%0b, required 8 0", level, wr_ready);
        end
        wr_valid = 1'b1;
        wr_data = 32'd99;
        req = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || dout !== 32'd10 || level !== 4'd7 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_serve: ack=%0b dout=%0d level=%0d wr_ready=%0b, required 1 10 7 1",
                     ack, dout, level, wr_ready);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                checks++;
                if (dout !== 32'(11 + got)) begin
                    failures++;
                    $display("[TB] FAIL full_drain%0d: dout=%0d, required %0d", got, dout, 11 + got);
                end
                got++;
            end
        end
        req = 1'b0;
        checks++;
        if (got != 7 || level !== 4'd0 || count !== 32'd11) begin
            failures++;
            $display("[TB] FAIL full_totals: acks=%0d level=%0d count=%0d, required 7 0 11", got, level, count);
        end
    endtask

    // Push into an empty FIFO with req already high: ack one edge later.
    task automatic test_empty_push();
        @(negedge clk);
        req = 1'b1;
        wr_valid = 1'b1;
        wr_data = 32'd5;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (ack !== 1'b0 || level !== 4'd1) begin
            failures++;
            $display("[TB] FAIL empty_push_edge: ack=%0b level=%0d, required 0 1", ack, level);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || dout !== 32'd5 || level !== 4'd0) begin
            failures++;
            $display("[TB] FAIL empty_push_next: ack=%0b dout=%0d level=%0d, required 1 5 0", ack, dout, level);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    // Stream 0..40 through the FIFO so both pointers wrap several times.
    task automatic test_wrap();
        int nxt;
        int got;
        int max_level;
        nxt = 0;
        got = 0;
        max_level = 0;
        req = 1'b1;
        for (int i = 0; i < 300 && got < 41; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                checks++;
                if (dout !== 32'(got)) begin
                    failures++;
                    $display("[TB] FAIL wrap_word%0d: dout=%0d, required %0d", got, dout, got);
                end
                got++;
            end
            if (int'(level) > max_level) max_level = int'(level);
            if (nxt <= 40 && level < 4'd4) begin
                wr_valid = 1'b1;
                wr_data = 32'(nxt);
                nxt++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
        req = 1'b0;
        checks++;
        if (got != 41 || max_level > 7 || level !== 4'd0 || count !== 32'd53) begin
            failures++;
            $display("[TB] FAIL wrap_totals: words=%0d max_level=%0d level=%0d count=%0d, required 41 <=7 0 53",
                     got, max_level, level, count);
        end
    endtask

    // Reset while four words are buffered and req is active; stale data gone.
    task automatic test_mid_reset();
        int waited;
        waited = 0;
        for (int v = 1; v <= 4; v++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data = 32'(100 + v);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (level !== 4'd4) begin
            failures++;
            $display("[TB] FAIL midreset_setup: level=%0d, required 4", level);
        end
        req = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ack !== 1'b0 || dout !== 32'd0 || level !== 4'd0 || count !== 32'd0 || wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_state: ack=%0b dout=%0d level=%0d count=%0d wr_ready=%0b, required 0 0 0 0 1",
                     ack, dout, level, count, wr_ready);
        end
        wr_valid = 1'b1;
        wr_data = 32'd7;
        @(negedge clk);
        wr_valid = 1'b0;
        while (ack !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ack !== 1'b1 || dout !== 32'd7 || count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL midreset_serve: ack=%0b dout=%0d count=%0d, required 1 7 1", ack, dout, count);
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_three();
        test_full();
        test_empty_push();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
